// File: rtl/sfx_tone_arbiter.sv
// Purpose: shares the tone datapath between background music and three sound-effect requesters.
// Latency: 1 clk from sfx_req (or music_tone in IDLE) to the registered tone/duty/grant outputs.
// Backpressure: none; requests are fire-and-forget and are played, retriggered, queued or dropped.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active high
//   music_tone  background tone word from the music sequencer
//   music_en    1 = pass music while no effect is active, 0 = silence
//   sfx_req     per-requester request (bit 2 = highest priority), sampled every clk
//   tone        tone word to the PWM generator (registered)
//   duty        duty word to the PWM generator (registered, 0 whenever tone is 0)
//   grant       one-hot requester currently playing, 0 otherwise
//   sfx_active  1 while an effect or its trailing gap is in progress
//
// Build option: define SFX_QUEUE_EN to remember lower-priority requests that arrive
// during PLAY and all requests arriving during GAP; they are served highest-first once
// the current effect and its gap finish. Without it those requests are discarded.

module sfx_tone_arbiter #(
  parameter logic [23:0] DUR_CYC = 24'd10_000_000,
  parameter logic [23:0] GAP_CYC = 24'd1_000_000,
  parameter logic [31:0] TONE0   = 32'd523,
  parameter logic [31:0] TONE1   = 32'd659,
  parameter logic [31:0] TONE2   = 32'd784,
  parameter logic [9:0]  DUTY    = 10'd512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] music_tone,
  input  logic        music_en,
  input  logic [2:0]  sfx_req,
  output logic [31:0] tone,
  output logic [9:0]  duty,
  output logic [2:0]  grant,
  output logic        sfx_active
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  // Counters are loaded with length-1 so that a load followed by counting down to 0
  // spans exactly the requested number of cycles.
  localparam logic [23:0] DUR_LOAD = DUR_CYC - 24'd1;
  localparam logic [23:0] GAP_LOAD = GAP_CYC - 24'd1;

  state_t      state;
  logic [23:0] counter;
  logic [1:0]  cur;
  logic [2:0]  pend;

  state_t      nxt_state;
  logic [23:0] nxt_cnt;
  logic [1:0]  nxt_idx;
  logic [2:0]  pend_set;
  logic [2:0]  pend_clr;
  logic [2:0]  pend_nxt;
  logic        next_sel;

  logic        req_any;
  logic [1:0]  req_top;
  logic [2:0]  qreq;
  logic [2:0]  pend_all;
  logic [1:0]  pend_top;

  function automatic logic [1:0] top_idx(input logic [2:0] v);
    if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else return 2'd0;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  function automatic logic [31:0] sfx_tone(input logic [1:0] i);
    case (i)
      2'd2:    return TONE2;
      2'd1:    return TONE1;
      default: return TONE0;
    endcase
  endfunction

  // qreq is the set of requests eligible for queueing; forcing it to zero removes the
  // queue entirely, leaving pend a register that only ever holds 0.
`ifdef SFX_QUEUE_EN
  assign qreq = sfx_req;
`else
  assign qreq = 3'b000;
`endif

  assign req_any  = |sfx_req;
  assign req_top  = top_idx(sfx_req);
  // Requests arriving in the cycle that triggers next-select are considered together
  // with already-pending ones, so nothing waits an extra cycle.
  assign pend_all = pend | qreq;
  assign pend_top = top_idx(pend_all);
  assign pend_nxt = (pend | pend_set) & ~pend_clr;

  always_comb begin
    nxt_state = state;
    nxt_idx   = cur;
    nxt_cnt   = counter;
    pend_set  = 3'b000;
    pend_clr  = 3'b000;
    next_sel  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          nxt_state = S_PLAY;
          nxt_idx   = req_top;
          nxt_cnt   = DUR_LOAD;
          pend_set  = qreq & ~onehot(req_top);
        end
      end
      S_PLAY: begin
        // Equal or higher priority wins over expiry: retrigger or preempt, and the
        // preempted effect is simply dropped.
        if (req_any && (req_top >= cur)) begin
          nxt_idx  = req_top;
          nxt_cnt  = DUR_LOAD;
          pend_set = qreq & ~onehot(req_top);
        end else begin
          pend_set = qreq;
          if (counter != 24'd0) begin
            nxt_cnt = counter - 24'd1;
          end else if (GAP_CYC != 24'd0) begin
            nxt_state = S_GAP;
            nxt_cnt   = GAP_LOAD;
          end else begin
            next_sel = 1'b1;
          end
        end
      end
      S_GAP: begin
        pend_set = qreq;
        if (counter != 24'd0) nxt_cnt = counter - 24'd1;
        else next_sel = 1'b1;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = 24'd0;
      end
    endcase

    if (next_sel) begin
      if (pend_all != 3'b000) begin
        nxt_state = S_PLAY;
        nxt_idx   = pend_top;
        nxt_cnt   = DUR_LOAD;
        pend_clr  = onehot(pend_top);
      end else begin
        nxt_state = S_IDLE;
        nxt_cnt   = 24'd0;
      end
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      counter    <= 24'd0;
      cur        <= 2'd0;
      pend       <= 3'b000;
      tone       <= 32'd0;
      duty       <= 10'd0;
      grant      <= 3'b000;
      sfx_active <= 1'b0;
    end else begin
      state   <= nxt_state;
      counter <= nxt_cnt;
      cur     <= nxt_idx;
      pend    <= pend_nxt;
      case (nxt_state)
        S_PLAY: begin
          tone       <= sfx_tone(nxt_idx);
          duty       <= (sfx_tone(nxt_idx) != 32'd0) ? DUTY : 10'd0;
          grant      <= onehot(nxt_idx);
          sfx_active <= 1'b1;
        end
        S_GAP: begin
          tone       <= 32'd0;
          duty       <= 10'd0;
          grant      <= 3'b000;
          sfx_active <= 1'b1;
        end
        default: begin
          tone       <= music_en ? music_tone : 32'd0;
          duty       <= (music_en && (music_tone != 32'd0)) ? DUTY : 10'd0;
          grant      <= 3'b000;
          sfx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sfx_tone_arbiter.sv
// Purpose: self-checking bench for sfx_tone_arbiter with short play/gap lengths.
// Latency: expects outputs one clk after each driven input set.
// Backpressure: not applicable; inputs are driven every cycle.

module tb_sfx_tone_arbiter;

  localparam int DUR = 8;
  localparam int GAP = 2;
`ifdef SFX_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] music_tone = 32'd440;
  logic        music_en = 1'b1;
  logic [2:0]  sfx_req = 3'b000;
  logic [31:0] tone;
  logic [9:0]  duty;
  logic [2:0]  grant;
  logic        sfx_active;

  int compared = 0;
  int mismatched = 0;

  sfx_tone_arbiter #(
    .DUR_CYC(24'd8),
    .GAP_CYC(24'd2),
    .TONE0(32'd523),
    .TONE1(32'd659),
    .TONE2(32'd784),
    .DUTY(10'd512)
  ) dut (
    .clk(clk),
    .rst(rst),
    .music_tone(music_tone),
    .music_en(music_en),
    .sfx_req(sfx_req),
    .tone(tone),
    .duty(duty),
    .grant(grant),
    .sfx_active(sfx_active)
  );

  always #5 clk = ~clk;

  logic [45:0] obs;
  assign obs = {tone, duty, grant, sfx_active};

  // Reference model: an effect is either playing (with cycles left), in its gap
  // (with cycles left) or nothing is happening and music passes through.
  logic [31:0] tones [3] = '{32'd523, 32'd659, 32'd784};
  int          m_k = -1;
  int          m_play = 0;
  int          m_gap = 0;
  bit [2:0]    m_pend = 3'b000;
  logic [45:0] exp_vec = '0;

  function automatic int highest(input bit [2:0] v);
    for (int i = 2; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void m_queue(input bit [2:0] v);
    if (QEN) m_pend = m_pend | v;
  endfunction

  function automatic void m_next();
    int k;
    k = highest(m_pend);
    if (k >= 0) begin
      m_pend[k] = 1'b0;
      m_k = k;
      m_play = DUR;
    end
  endfunction

  function automatic void model_step(input bit r, input bit [2:0] q, input logic [31:0] mt, input bit me);
    int top;
    if (r) begin
      m_k = -1; m_play = 0; m_gap = 0; m_pend = 3'b000;
      exp_vec = '0;
      return;
    end
    top = highest(q);
    if (m_k >= 0) begin
      if (top >= m_k) begin
        q[top] = 1'b0; m_queue(q); m_k = top; m_play = DUR;
      end else begin
        m_queue(q);
        m_play--;
        if (m_play == 0) begin
          m_k = -1;
          if (GAP > 0) m_gap = GAP;
          else m_next();
        end
      end
    end else if (m_gap > 0) begin
      m_queue(q);
      m_gap--;
      if (m_gap == 0) m_next();
    end else if (top >= 0) begin
      q[top] = 1'b0; m_queue(q); m_k = top; m_play = DUR;
    end
    if (m_k >= 0) exp_vec = {tones[m_k], 10'd512, 3'(1 << m_k), 1'b1};
    else if (m_gap > 0) exp_vec = {32'd0, 10'd0, 3'd0, 1'b1};
    else exp_vec = {me ? mt : 32'd0, (me && mt != 32'd0) ? 10'd512 : 10'd0, 3'd0, 1'b0};
  endfunction

  function automatic logic [45:0] mk(input int t, input int d, input logic [2:0] g, input logic a);
    return {32'(t), 10'(d), g, a};
  endfunction

  function automatic string show(input logic [45:0] v);
    return $sformatf("tone=%0d duty=%0d grant=%b act=%b", v[45:14], v[13:4], v[3:1], v[0]);
  endfunction

  task automatic tick(input bit r, input bit [2:0] q);
    @(negedge clk);
    rst = r;
    sfx_req = q;
    model_step(r, q, music_tone, music_en);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [45:0] e;
    music_tone = 32'd440; music_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(i < 3, 3'b000);
      e = (i < 3) ? mk(0, 0, 3'b000, 1'b0) : mk(440, 512, 3'b000, 1'b0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL reset step %0d: got %s want %s", i, show(obs), show(e));
      end
    end
  endtask

  task automatic test_single();
    logic [45:0] e;
    for (int i = 0; i < 11; i++) begin
      tick(1'b0, (i == 0) ? 3'b001 : 3'b000);
      if (i < 8) e = mk(523, 512, 3'b001, 1'b1);
      else if (i < 10) e = mk(0, 0, 3'b000, 1'b1);
      else e = mk(440, 512, 3'b000, 1'b0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL single step %0d: got %s want %s", i, show(obs), show(e));
      end
    end
  endtask

  task automatic test_preempt();
    logic [45:0] e;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, (i == 0) ? 3'b001 : (i == 3) ? 3'b100 : 3'b000);
      if (i < 3) e = mk(523, 512, 3'b001, 1'b1);
      else if (i < 11) e = mk(784, 512, 3'b100, 1'b1);
      else if (i < 13) e = mk(0, 0, 3'b000, 1'b1);
      else e = mk(440, 512, 3'b000, 1'b0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL preempt step %0d: got %s want %s", i, show(obs), show(e));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [45:0] e;
    int n;
    n = QEN ? 21 : 11;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, (i == 0) ? 3'b011 : 3'b000);
      if (i < 8) e = mk(659, 512, 3'b010, 1'b1);
      else if (i < 10) e = mk(0, 0, 3'b000, 1'b1);
      else if (QEN && i < 18) e = mk(523, 512, 3'b001, 1'b1);
      else if (QEN && i < 20) e = mk(0, 0, 3'b000, 1'b1);
      else e = mk(440, 512, 3'b000, 1'b0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL simultaneous step %0d: got %s want %s", i, show(obs), show(e));
      end
    end
  endtask

  task automatic test_retrigger();
    logic [45:0] e;
    for (int i = 0; i < 17; i++) begin
      tick(1'b0, (i == 0 || i == 6) ? 3'b010 : 3'b000);
      if (i < 14) e = mk(659, 512, 3'b010, 1'b1);
      else if (i < 16) e = mk(0, 0, 3'b000, 1'b1);
      else e = mk(440, 512, 3'b000, 1'b0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL retrigger step %0d: got %s want %s", i, show(obs), show(e));
      end
    end
  endtask

  task automatic test_mute_and_music();
    logic [45:0] e;
    for (int i = 0; i < 14; i++) begin
      case (i)
        0: begin music_en = 1'b0; music_tone = 32'd440; end
        1: begin music_en = 1'b1; music_tone = 32'd0; end
        2: music_tone = 32'd1000;
        5: music_tone = 32'd300;
        default: ;
      endcase
      tick(1'b0, (i == 3) ? 3'b001 : 3'b000);
      if (i < 2) e = mk(0, 0, 3'b000, 1'b0);
      else if (i == 2) e = mk(1000, 512, 3'b000, 1'b0);
      else if (i < 11) e = mk(523, 512, 3'b001, 1'b1);
      else if (i < 13) e = mk(0, 0, 3'b000, 1'b1);
      else e = mk(300, 512, 3'b000, 1'b0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL mute_music step %0d: got %s want %s", i, show(obs), show(e));
      end
    end
    music_tone = 32'd440;
    tick(1'b0, 3'b000);
  endtask

  task automatic test_reset_mid_play();
    logic [45:0] e;
    for (int i = 0; i < 18; i++) begin
      tick(i == 4, (i == 0) ? 3'b110 : 3'b000);
      if (i < 4) e = mk(784, 512, 3'b100, 1'b1);
      else if (i == 4) e = mk(0, 0, 3'b000, 1'b0);
      else e = mk(440, 512, 3'b000, 1'b0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL reset_mid_play step %0d: got %s want %s", i, show(obs), show(e));
      end
    end
  endtask

  task automatic test_random();
    bit [2:0] q;
    bit       r;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 3) music_tone = 32'($urandom_range(0, 2000));
      if ($urandom_range(0, 99) < 2) music_en = ~music_en;
      q = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      r = ($urandom_range(0, 299) == 0);
      tick(r, q);
      compared++;
      if (obs !== exp_vec) begin
        mismatched++;
        $display("FAIL random cycle %0d: got %s want %s", i, show(obs), show(exp_vec));
      end
    end
    music_en = 1'b1;
    music_tone = 32'd440;
  endtask

  initial begin
    test_reset();
    test_single();
    test_preempt();
    test_simultaneous();
    test_retrigger();
    test_mute_and_music();
    test_reset_mid_play();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
